debounce_array: RTL and testbench

DEBOUNCE_ARRAY -- requirements
Module: debounce_array

---
 rtl/debounce_array.sv | 122 ++++++++++++
 tb/tb_debounce_array.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/debounce_array.sv
// Per-channel synchronizer + stability-counter debouncer with registered level/rise/fall.
// Optional auto-repeat on rise is compiled in only when DEBOUNCE_REPEAT_EN is defined.
module debounce_array #(
  parameter int          CHANNELS      = 11,
  parameter int          SYNC_STAGES   = 2,
  parameter int          STABLE_CNT    = 500000,
  parameter int          CNT_W         = 20,
  parameter int          REPEAT_DELAY  = 50000000,
  parameter int          REPEAT_PERIOD = 10000000,
  parameter logic [31:0] REPEAT_MASK   = 32'd0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] raw,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall
);

  logic [SYNC_STAGES-1:0][CHANNELS-1:0] r_sync;
  logic [CHANNELS-1:0]                  w_sync;

  assign w_sync = r_sync[SYNC_STAGES-1];

  // synchronizer chain for all raw inputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync[0] <= raw;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        r_sync[s] <= r_sync[s-1];
      end
    end
  end

`ifdef DEBOUNCE_REPEAT_EN
  localparam int RW = $clog2(REPEAT_DELAY + REPEAT_PERIOD + 1);
`else
  logic w_unused_cfg;
  assign w_unused_cfg = ^{REPEAT_MASK, REPEAT_DELAY, REPEAT_PERIOD};
`endif

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             r_level;
    logic             r_rise;
    logic             r_fall;
    logic             w_toggle;
    logic             w_rep_hit;

    assign level[i] = r_level;
    assign rise[i]  = r_rise;
    assign fall[i]  = r_fall;

    // stability counter increment and acceptance decision
    always_comb begin
      w_cnt_inc = r_cnt + CNT_W'(1);
      w_toggle  = 1'b0;
      if (w_sync[i] != r_level) begin
        w_toggle = (w_cnt_inc == CNT_W'(STABLE_CNT));
      end else begin
        w_toggle = 1'b0;
      end
    end

    // debounced level, counter and edge pulses
    always_ff @(posedge clk) begin
      if (rst) begin
        r_cnt   <= '0;
        r_level <= 1'b0;
        r_rise  <= 1'b0;
        r_fall  <= 1'b0;
      end else begin
        if (w_sync[i] == r_level || w_toggle) begin
          r_cnt <= '0;
        end else begin
          r_cnt <= w_cnt_inc;
        end
        if (w_toggle) begin
          r_level <= ~r_level;
        end
        r_rise <= (w_toggle & ~r_level) | w_rep_hit;
        r_fall <= w_toggle & r_level;
      end
    end

`ifdef DEBOUNCE_REPEAT_EN
    logic [RW-1:0] r_rcnt;
    logic [RW-1:0] w_rcnt_inc;
    logic          r_rphase;

    // repeat interval: first REPEAT_DELAY after the press, then REPEAT_PERIOD
    always_comb begin
      w_rcnt_inc = r_rcnt + RW'(1);
      w_rep_hit  = 1'b0;
      if (REPEAT_MASK[i] && r_level && !w_toggle) begin
        w_rep_hit = (w_rcnt_inc == (r_rphase ? RW'(REPEAT_PERIOD) : RW'(REPEAT_DELAY)));
      end else begin
        w_rep_hit = 1'b0;
      end
    end

    // repeat counter restarts on any level change and idles while released
    always_ff @(posedge clk) begin
      if (rst || !r_level || w_toggle) begin
        r_rcnt   <= '0;
        r_rphase <= 1'b0;
      end else if (w_rep_hit) begin
        r_rcnt   <= '0;
        r_rphase <= 1'b1;
      end else begin
        r_rcnt   <= w_rcnt_inc;
      end
    end
`else
    assign w_rep_hit = 1'b0;
`endif
  end

endmodule

// File: tb/tb_debounce_array.sv
// Directed self-checking bench for debounce_array (4 channels, STABLE_CNT=4, repeat on channel 2).
module tb_debounce_array;

  logic       clk;
  logic       rst;
  logic [3:0] raw;
  logic [3:0] level;
  logic [3:0] rise;
  logic [3:0] fall;

  int n_checks;
  int n_errors;
  int n_rise2;
  int n_rise0;

  debounce_array #(
    .CHANNELS(4), .SYNC_STAGES(2), .STABLE_CNT(4), .CNT_W(20),
    .REPEAT_DELAY(10), .REPEAT_PERIOD(3), .REPEAT_MASK(32'h4)
  ) dut (
    .clk(clk), .rst(rst), .raw(raw), .level(level), .rise(rise), .fall(fall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk3(input string tag, input logic [3:0] el, input logic [3:0] er, input logic [3:0] ef);
    chk($sformatf("%s level", tag), {28'd0, level}, {28'd0, el});
    chk($sformatf("%s rise", tag), {28'd0, rise}, {28'd0, er});
    chk($sformatf("%s fall", tag), {28'd0, fall}, {28'd0, ef});
  endtask

  initial begin
    bit rep_en;
    logic [3:0] er;
    n_checks = 0;
    n_errors = 0;
    n_rise2  = 0;
    n_rise0  = 0;
`ifdef DEBOUNCE_REPEAT_EN
    rep_en = 1'b1;
`else
    rep_en = 1'b0;
`endif
    rst = 1'b1;
    raw = 4'b0000;
    tick(); tick(); tick();
    rst = 1'b0;
    tick();
    chk3("reset", 4'b0000, 4'b0000, 4'b0000);

    // clean press on channel 0: accepted 6 cycles later
    raw = 4'b0001;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk3($sformatf("ch0 press k=%0d", k), (k >= 6) ? 4'b0001 : 4'b0000,
           (k == 6) ? 4'b0001 : 4'b0000, 4'b0000);
    end
    raw = 4'b0000;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk3($sformatf("ch0 release k=%0d", k), (k >= 6) ? 4'b0000 : 4'b0001,
           4'b0000, (k == 6) ? 4'b0001 : 4'b0000);
    end

    // glitch train on channel 1: 3 high, 1 low, never long enough
    for (int k = 0; k < 24; k++) begin
      raw = ((k % 4) != 3) ? 4'b0010 : 4'b0000;
      tick();
      chk3($sformatf("ch1 glitch k=%0d", k), 4'b0000, 4'b0000, 4'b0000);
    end
    raw = 4'b0000;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk3($sformatf("ch1 settle k=%0d", k), 4'b0000, 4'b0000, 4'b0000);
    end

    // simultaneous transitions on channels 0,1,3
    raw = 4'b1011;
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk3($sformatf("multi press k=%0d", k), (k >= 6) ? 4'b1011 : 4'b0000,
           (k == 6) ? 4'b1011 : 4'b0000, 4'b0000);
    end
    raw = 4'b0000;
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk3($sformatf("multi release k=%0d", k), (k >= 6) ? 4'b0000 : 4'b1011,
           4'b0000, (k == 6) ? 4'b1011 : 4'b0000);
    end

    // reset in the middle of a count on channel 3
    raw = 4'b1000;
    tick(); tick();
    rst = 1'b1;
    tick();
    chk3("mid rst a", 4'b0000, 4'b0000, 4'b0000);
    tick();
    chk3("mid rst b", 4'b0000, 4'b0000, 4'b0000);
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk3($sformatf("ch3 after rst k=%0d", k), (k >= 6) ? 4'b1000 : 4'b0000,
           (k == 6) ? 4'b1000 : 4'b0000, 4'b0000);
    end
    raw = 4'b0000;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk3($sformatf("ch3 release k=%0d", k), (k >= 6) ? 4'b0000 : 4'b1000,
           4'b0000, (k == 6) ? 4'b1000 : 4'b0000);
    end

    // long hold on channels 0 and 2; only channel 2 may auto-repeat
    raw = 4'b0101;
    for (int k = 1; k <= 42; k++) begin
      tick();
      er = 4'b0000;
      if (k == 6) er = 4'b0101;
      if (rep_en && k >= 16 && k < 36 && ((k - 16) % 3) == 0) er[2] = 1'b1;
      chk3($sformatf("hold k=%0d", k), (k >= 6 && k < 36) ? 4'b0101 : 4'b0000,
           er, (k == 36) ? 4'b0101 : 4'b0000);
      if (rise[2]) n_rise2++;
      if (rise[0]) n_rise0++;
      if (k == 30) raw = 4'b0000;
    end
    chk("rise2 pulse count", n_rise2, rep_en ? 32'd8 : 32'd1);
    chk("rise0 pulse count", n_rise0, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
